// File: rtl/instr_assembler_pkg.sv
// Shared types and opcode classification for the SM83 instruction assembler.
package instr_assembler_pkg;

  typedef logic [7:0] opcode8_t;

  localparam opcode8_t OP_PREFIX_CB = 8'hCB;

  typedef enum logic [1:0] {
    S_OPC    = 2'd0,
    S_CB     = 2'd1,
    S_IMM_LO = 2'd2,
    S_IMM_HI = 2'd3
  } asm_state_t;

  typedef struct packed {
    opcode8_t    opcode;
    logic        is_cb;
    logic [15:0] imm;
    logic [1:0]  len;
    logic [15:0] pc;
    logic        illegal;
  } instr_rec_t;

  // Total instruction length in bytes for an unprefixed first byte.
  function automatic logic [1:0] instr_len(opcode8_t op);
    if (op inside {8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
                   8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
                   8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA})
      return 2'd3;
    if (op inside {8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                   8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
                   8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
                   8'hE0, 8'hF0, 8'hE8, 8'hF8})
      return 2'd2;
    return 2'd1;
  endfunction

  // Opcodes with no defined SM83 instruction.
  function automatic logic is_illegal_op(opcode8_t op);
    return op inside {8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
                      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD};
  endfunction

endpackage

// File: rtl/instr_assembler_if.sv
// Fetch-side byte handshake plus decode-side instruction record handshake.
interface instr_assembler_if;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        flush;
  logic [15:0] flush_pc;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode;
  logic        out_is_cb;
  logic [15:0] out_imm;
  logic [1:0]  out_len;
  logic [15:0] out_pc;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_byte, flush, flush_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_is_cb, out_imm, out_len,
           out_pc, out_illegal
  );

  modport master (
    output in_valid, in_byte, flush, flush_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_is_cb, out_imm, out_len,
           out_pc, out_illegal
  );
endinterface

// File: rtl/instr_rec_fifo.sv
// Circular queue of instruction records with synchronous clear and registered count.
module instr_rec_fifo
  import instr_assembler_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  instr_rec_t    din,
  input  logic          pop,
  output instr_rec_t    dout,
  output logic [CW-1:0] count
);

  instr_rec_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              pop_ok;

  // A pop on an empty queue is ignored; pushes are only offered when not full.
  assign pop_ok = pop && (count != '0);
  assign dout   = mem[rd_ptr];

  // Storage, pointers and occupancy; clear wins over any push/pop that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/instr_assembler.sv
// Gathers SM83 opcode bytes into whole instruction records with PC tracking.
module instr_assembler
  import instr_assembler_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] PC_RESET = 16'h0100
) (
  input logic            clk,
  input logic            rst_n,
  instr_assembler_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  asm_state_t    state_q, state_d;
  opcode8_t      opc_q;
  logic [7:0]    imm_lo_q;
  logic          need_hi_q;
  logic [15:0]   start_pc_q, pc_q;
  logic          accept, push, full;
  instr_rec_t    rec, head;
  logic [CW-1:0] count;

  assign full         = (count == CW'(DEPTH));
  assign bus.in_ready = !full && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // State register; a redirect always restarts at an opcode boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         state_q <= S_OPC;
    else if (bus.flush) state_q <= S_OPC;
    else                state_q <= state_d;
  end

  // Next state and the record pushed on the byte that completes an instruction.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    rec     = '0;
    if (accept) begin
      case (state_q)
        S_OPC: begin
          if (bus.in_byte == OP_PREFIX_CB)           state_d = S_CB;
          else if (instr_len(bus.in_byte) != 2'd1)   state_d = S_IMM_LO;
          else begin
            push        = 1'b1;
            rec.opcode  = bus.in_byte;
            rec.len     = 2'd1;
            rec.pc      = pc_q;
            rec.illegal = is_illegal_op(bus.in_byte);
          end
        end
        S_CB: begin
          push       = 1'b1;
          rec.opcode = bus.in_byte;
          rec.is_cb  = 1'b1;
          rec.len    = 2'd2;
          rec.pc     = start_pc_q;
          state_d    = S_OPC;
        end
        S_IMM_LO: begin
          if (need_hi_q) state_d = S_IMM_HI;
          else begin
            push       = 1'b1;
            rec.opcode = opc_q;
            rec.imm    = {8'h00, bus.in_byte};
            rec.len    = 2'd2;
            rec.pc     = start_pc_q;
            state_d    = S_OPC;
          end
        end
        S_IMM_HI: begin
          push       = 1'b1;
          rec.opcode = opc_q;
          rec.imm    = {bus.in_byte, imm_lo_q};
          rec.len    = 2'd3;
          rec.pc     = start_pc_q;
          state_d    = S_OPC;
        end
        default: state_d = S_OPC;
      endcase
    end
  end

  // PC counter and partial-instruction latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= PC_RESET;
      start_pc_q <= '0;
      opc_q      <= '0;
      imm_lo_q   <= '0;
      need_hi_q  <= 1'b0;
    end else if (bus.flush) begin
      pc_q <= bus.flush_pc;
    end else if (accept) begin
      pc_q <= pc_q + 16'd1;
      if (state_q == S_OPC) begin
        start_pc_q <= pc_q;
        opc_q      <= bus.in_byte;
        need_hi_q  <= (instr_len(bus.in_byte) == 2'd3);
      end
      if (state_q == S_IMM_LO) imm_lo_q <= bus.in_byte;
    end
  end

  instr_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (bus.flush),
    .push  (push),
    .din   (rec),
    .pop   (bus.out_ready),
    .dout  (head),
    .count (count)
  );

  assign bus.out_valid   = (count != '0);
  assign bus.out_opcode  = head.opcode;
  assign bus.out_is_cb   = head.is_cb;
  assign bus.out_imm     = head.imm;
  assign bus.out_len     = head.len;
  assign bus.out_pc      = head.pc;
  assign bus.out_illegal = head.illegal;

endmodule

// File: doc/instr_assembler.md
# instr_assembler

Byte-stream instruction assembler between fetch and the SM83 decode stage. Accepts one opcode-stream byte per handshake and classifies each first byte by instruction length (1/2/3, CB-prefixed, illegal). Gathers the 8/16-bit immediate bytes and pushes one complete instruction record per instruction into a parametrised output queue. Decode and control consume whole instructions, with PC tracking and flush-on-redirect.

## Interface
- `DEPTH`, 4: output queue entries; power of two, ≥2.
- `PC_RESET`, 16'h0100: PC of the first byte after reset.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: fetch byte valid.
- `in_byte` in 8: fetch byte.
- `in_ready` out 1: byte accepted when `in_valid & in_ready`.
- `flush` in 1: redirect pulse; discards partial and queued instructions.
- `flush_pc` in 16: PC of the next byte after `flush`.
- `out_valid` out 1: queue head valid.
- `out_ready` in 1: head popped when `out_valid & out_ready`.
- `out_opcode` out 8: opcode; for CB instructions, the byte after 0xCB.
- `out_is_cb` out 1: instruction was CB-prefixed.
- `out_imm` out 16: immediate; imm8 in [7:0] with [15:8]=0; 0 if none.
- `out_len` out 2: total bytes, 1..3.
- `out_pc` out 16: address of the instruction's first byte.
- `out_illegal` out 1: opcode in the illegal set.

## Operation
- Assembler FSM states: S_OPC, S_CB, S_IMM_LO, S_IMM_HI.
- S_OPC, accepted byte b:
  - b==0xCB → S_CB.
  - Length 2 → latch opcode, go to S_IMM_LO with `need_hi`=0.
  - Length 3 → latch opcode, go to S_IMM_LO with `need_hi`=1.
  - Length 1 → push record, stay in S_OPC.
- S_CB: accepted byte → push {opcode=byte, is_cb=1, len=2, imm=0} → S_OPC.
- S_IMM_LO: latch imm[7:0]. If `need_hi`=1 → S_IMM_HI; otherwise push the record → S_OPC.
- S_IMM_HI: latch imm[15:8], push the record → S_OPC.
- Length 2 opcodes:
  - 0x06/0E/16/1E/26/2E/36/3E (LD r,d8)
  - 0x10 (STOP)
  - 0x18/20/28/30/38 (JR)
  - 0xC6/CE/D6/DE/E6/EE/F6/FE (ALU d8)
  - 0xE0, 0xF0, 0xE8, 0xF8
- Length 3 opcodes:
  - 0x01/11/21/31 (LD r16,d16), 0x08
  - 0xC2/C3/C4/CA/CC/CD/D2/D4/DA/DC
  - 0xEA, 0xFA
- Illegal set: 0xD3/DB/DD/E3/E4/EB/EC/ED/F4/FC/FD. These are length 1 with `out_illegal`=1.
- All other opcodes are length 1.
- PC counter:
  - Increments by 1 on every accepted byte, 16-bit wrap 0xFFFF→0x0000.
  - `start_pc` is captured on each byte accepted in S_OPC.
  - A record spanning the wrap carries the pre-wrap `out_pc`.
- Queue: circular buffer with `log2(DEPTH)+1`-bit count. Head drives the `out_*` fields directly.
- `in_ready` = !full && !flush. It is derived from registered count only, with no combinational path from `out_ready`.
- A byte is accepted only when `in_ready`=1, so a completing byte is never accepted while the queue is full.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Flush:
  - Next edge: queue emptied, FSM→S_OPC, partial record dropped, PC←`flush_pc`.
  - Any `in_valid` byte in the flush cycle is dropped.
  - A pop in the flush cycle is still a pop; no effect beyond the empty queue.
- Reset values:
  - FSM=S_OPC, count=0, pointers=0, PC=`PC_RESET`.
  - `out_valid`=0, `in_ready`=1.
  - `out_*` data fields = 0.

## Timing
- Push occurs on the edge that accepts the final byte.
- `out_valid` rises the following cycle, giving 1 cycle latency from the final byte to the record.
- Throughput is one byte per cycle. Back-to-back 1-byte instructions fill the queue at 1/cycle.
- Full queue: `in_ready` drops in the cycle count==DEPTH. It rises the cycle after a pop.
- Flush: `out_valid`=0 and `in_ready`=1 one cycle after `flush` is asserted.
- Reset is asynchronous on assert and synchronous on deassert, via an external synchroniser.

## Structure
- `sm83_pkg` additions:
  - `asm_state_t` enum.
  - `instr_rec_t` packed struct {opcode, is_cb, imm, len, pc, illegal}.
  - Function `instr_len(opcode8_t)` returning 2'd1/2/3.
  - Function `is_illegal_op(opcode8_t)`.
  - Constant `OP_PREFIX_CB`=8'hCB.
- Sub-module `instr_rec_fifo`: parametrised `DEPTH` FIFO of `instr_rec_t`, with clear input and registered count.
- The FSM, PC counter and length classification sit in the top level.

## Test plan
- Bytes 00,3E,42,C3,34,12 with out_ready=1 → three records:
  - {00, len1, pc 0100}
  - {3E, imm 0042, len2, pc 0101}
  - {C3, imm 1234, len3, pc 0103}
- Bytes CB,7C → {opcode 7C, is_cb 1, len2, imm 0}. Byte D3 → {D3, illegal 1, len1}.
- DEPTH=4, out_ready=0, eight 0x00 bytes:
  - `in_ready` low after 4 records.
  - One pop re-opens `in_ready` next cycle.
  - No record is lost or duplicated.
- Flush with flush_pc=0x2000 after bytes 01,AA (mid-LD r16) → partial dropped, queue empty. Next byte 00 yields pc 2000.
- Flush with flush_pc=0xFFFE, then bytes FA,11,22,00 → records:
  - {FA, imm 2211, pc FFFE}
  - {00, pc 0001}
- Reset asserted while in S_IMM_HI with 2 queued records → all outputs return to reset values immediately. Next byte decodes at PC_RESET.
